// File: rtl/float_div_rcp_result_collect_if.sv
// Handshake bundle between the reciprocal pipe, this collector and the downstream consumer.
// The slave modport is the collector's view; the master modport is the surrounding environment's view.
interface float_div_rcp_result_collect_if #(
    parameter int DEPTH = 4,
    parameter int XW    = 37
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          issue_vld;
    logic          issue_rdy;
    logic          astall;
    logic [XW-1:0] rcp_x;
    logic          flush;
    logic          out_vld;
    logic          out_rdy;
    logic [XW-1:0] out_x;
    logic [CW-1:0] count;

    modport master (
        output issue_vld, rcp_x, flush, out_rdy,
        input  issue_rdy, astall, out_vld, out_x, count
    );

    modport slave (
        input  issue_vld, rcp_x, flush, out_rdy,
        output issue_rdy, astall, out_vld, out_x, count
    );
endinterface

// File: rtl/float_div_rcp_result_collect.sv
// Collects reciprocal-pipe results into a small FIFO; results appear on out_x the cycle after their push.
// Backpressure: when the FIFO is full and a result waits on the pipe output, astall freezes the whole pipe.
module float_div_rcp_result_collect #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4,
    parameter int XW      = 37
) (
    input logic                          aclk,
    input logic                          arst_n,
    float_div_rcp_result_collect_if.slave io
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [XW-1:0]      mem_q [DEPTH];

    logic stall;
    logic issue;
    logic push;
    logic pop;
    logic not_empty;

    // Stall depends only on registered state so the pipe enable never sees out_rdy or issue_vld.
    assign stall     = vld_q[LATENCY-1] && (count_q == FULL);
    assign not_empty = (count_q != '0);
    assign issue     = io.issue_vld && !stall;
    assign push      = vld_q[LATENCY-1] && !stall;
    assign pop       = not_empty && io.out_rdy;

    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (!stall) begin
            vld_d[0] = issue;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flush wins over everything, including an issue in the same cycle.
        if (io.flush) begin
            vld_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO masks out_x to zero.
    always_ff @(posedge aclk) begin
        if (push && !io.flush) begin
            mem_q[wr_ptr_q] <= io.rcp_x;
        end
    end

    assign io.astall    = stall;
    assign io.issue_rdy = !stall;
    assign io.out_vld   = not_empty;
    assign io.out_x     = not_empty ? mem_q[rd_ptr_q] : '0;
    assign io.count     = count_q;
endmodule

// File: tb/tb_float_div_rcp_result_collect.sv
// Drives two collectors (pipe latency 1 and 3) against a queue-level reference model of pipe + FIFO.
// The model also plays the reciprocal pipe: its last in-flight slot drives rcp_x.
module tb_float_div_rcp_result_collect;
    localparam int DEPTH = 4;
    localparam int XW    = 37;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int LAT [2] = '{1, 3};

    logic aclk   = 1'b0;
    logic arst_n = 1'b0;
    always #5 aclk = ~aclk;

    logic          iv   [2];
    logic [XW-1:0] op   [2];
    logic          fl   [2];
    logic          ordy [2];

    logic          mv   [2][8];
    logic [XW-1:0] md   [2][8];
    logic [XW-1:0] mbuf [2][64];
    int            mhead [2];
    int            mcnt  [2];
    int            accepted [2];
    int            delivered [2];
    int            discarded [2];

    int n_checks = 0;
    int n_fail   = 0;

    float_div_rcp_result_collect_if #(.DEPTH(DEPTH), .XW(XW)) if0 ();
    float_div_rcp_result_collect_if #(.DEPTH(DEPTH), .XW(XW)) if1 ();

    float_div_rcp_result_collect #(.LATENCY(LAT[0]), .DEPTH(DEPTH), .XW(XW)) dut0 (
        .aclk(aclk), .arst_n(arst_n), .io(if0)
    );
    float_div_rcp_result_collect #(.LATENCY(LAT[1]), .DEPTH(DEPTH), .XW(XW)) dut1 (
        .aclk(aclk), .arst_n(arst_n), .io(if1)
    );

    assign if0.issue_vld = iv[0];
    assign if0.flush     = fl[0];
    assign if0.out_rdy   = ordy[0];
    assign if0.rcp_x     = md[0][LAT[0]-1];
    assign if1.issue_vld = iv[1];
    assign if1.flush     = fl[1];
    assign if1.out_rdy   = ordy[1];
    assign if1.rcp_x     = md[1][LAT[1]-1];

    logic [XW-1:0] ox   [2];
    logic          ov   [2];
    logic          ast  [2];
    logic          irdy [2];
    logic [CW-1:0] cnt  [2];
    assign ox[0] = if0.out_x;   assign ox[1] = if1.out_x;
    assign ov[0] = if0.out_vld; assign ov[1] = if1.out_vld;
    assign ast[0] = if0.astall; assign ast[1] = if1.astall;
    assign irdy[0] = if0.issue_rdy; assign irdy[1] = if1.issue_rdy;
    assign cnt[0] = if0.count;  assign cnt[1] = if1.count;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic mstall(input int k);
        return mv[k][LAT[k]-1] && (mcnt[k] == DEPTH);
    endfunction

    function automatic int inflight(input int k);
        int n = 0;
        for (int i = 0; i < LAT[k]; i++) n += int'(mv[k][i]);
        return n;
    endfunction

    task automatic mclear(input int k);
        discarded[k] += mcnt[k] + inflight(k);
        for (int i = 0; i < 8; i++) mv[k][i] = 1'b0;
        mcnt[k]  = 0;
        mhead[k] = 0;
    endtask

    // One clock of the system as the rules describe it: stall, pop, push, then pipe advance.
    task automatic mstep(input int k);
        logic st;
        logic do_pop;
        logic do_push;
        st = mstall(k);
        if (fl[k]) begin
            mclear(k);
            return;
        end
        do_pop  = (mcnt[k] != 0) && ordy[k];
        do_push = mv[k][LAT[k]-1] && !st;
        if (do_push) begin
            mbuf[k][(mhead[k] + mcnt[k]) % 64] = md[k][LAT[k]-1];
            mcnt[k]++;
        end
        if (do_pop) begin
            mhead[k] = (mhead[k] + 1) % 64;
            mcnt[k]--;
            delivered[k]++;
        end
        if (!st) begin
            for (int i = LAT[k] - 1; i > 0; i--) begin
                mv[k][i] = mv[k][i-1];
                md[k][i] = md[k][i-1];
            end
            mv[k][0] = iv[k];
            md[k][0] = op[k];
            if (iv[k]) accepted[k]++;
        end
    endtask

    task automatic cmp_model(input int k);
        check($sformatf("count%0d", k), 64'(cnt[k]), 64'(mcnt[k]));
        check($sformatf("out_vld%0d", k), 64'(ov[k]), 64'(mcnt[k] != 0));
        check($sformatf("astall%0d", k), 64'(ast[k]), 64'(mstall(k)));
        check($sformatf("issue_rdy%0d", k), 64'(irdy[k]), 64'(!mstall(k)));
        if (mcnt[k] != 0) check($sformatf("out_x%0d", k), 64'(ox[k]), 64'(mbuf[k][mhead[k]]));
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge after checking.
    task automatic cycle();
        @(posedge aclk);
        #1;
        for (int k = 0; k < 2; k++) mstep(k);
        @(negedge aclk);
        for (int k = 0; k < 2; k++) cmp_model(k);
    endtask

    task automatic check_reset_outputs(input string tag, input int k);
        check({tag, "_vld"}, 64'(ov[k]), 64'(0));
        check({tag, "_cnt"}, 64'(cnt[k]), 64'(0));
        check({tag, "_stall"}, 64'(ast[k]), 64'(0));
        check({tag, "_rdy"}, 64'(irdy[k]), 64'(1));
        check({tag, "_x"}, 64'(ox[k]), 64'(0));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; op[k] = '0; fl[k] = 1'b0; ordy[k] = 1'b0;
            accepted[k] = 0; delivered[k] = 0; discarded[k] = 0;
            for (int i = 0; i < 8; i++) md[k][i] = '0;
            mclear(k);
        end
        #2;
        check_reset_outputs("rst0", 0);
        check_reset_outputs("rst1", 1);
        @(negedge aclk);
        arst_n = 1'b1;

        // Single result through the latency-1 instance.
        ordy[0] = 1'b1; ordy[1] = 1'b1;
        iv[0] = 1'b1; op[0] = 37'h0_0000_1234;
        cycle();
        iv[0] = 1'b0;
        check("single_vld_c1", 64'(ov[0]), 64'(0));
        cycle();
        check("single_vld_c2", 64'(ov[0]), 64'(1));
        check("single_x_c2", 64'(ox[0]), 64'h1234);
        cycle();
        check("single_cnt_c3", 64'(cnt[0]), 64'(0));

        // Five back-to-back into a stalled consumer: fifth result held on the pipe.
        ordy[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            iv[0] = 1'b1; op[0] = XW'(100 + i);
            cycle();
        end
        iv[0] = 1'b0;
        check("full_cnt", 64'(cnt[0]), 64'(4));
        check("full_stall", 64'(ast[0]), 64'(1));
        check("full_rdy", 64'(irdy[0]), 64'(0));
        check("full_head", 64'(ox[0]), 64'(101));
        cycle();
        check("full_hold", 64'(ast[0]), 64'(1));
        ordy[0] = 1'b1;
        cycle();
        ordy[0] = 1'b0;
        check("unstall", 64'(ast[0]), 64'(0));
        check("unstall_cnt", 64'(cnt[0]), 64'(3));
        cycle();
        check("refill_cnt", 64'(cnt[0]), 64'(4));
        ordy[0] = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("drain_%0d", i), 64'(ox[0]), 64'(100 + i));
            cycle();
        end
        check("drain_cnt", 64'(cnt[0]), 64'(0));

        // Simultaneous push and pop at occupancy two.
        ordy[0] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            iv[0] = 1'b1; op[0] = XW'(200 + i);
            cycle();
        end
        iv[0] = 1'b0;
        check("pp_cnt_before", 64'(cnt[0]), 64'(2));
        ordy[0] = 1'b1;
        cycle();
        check("pp_cnt_after", 64'(cnt[0]), 64'(2));
        check("pp_head", 64'(ox[0]), 64'(202));
        repeat (3) cycle();

        // Flush on the third issue of the latency-3 instance discards everything.
        for (int i = 0; i < 3; i++) begin
            iv[1] = 1'b1; op[1] = XW'(250 + i); fl[1] = (i == 2);
            cycle();
        end
        iv[1] = 1'b0; fl[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("flush_cnt_%0d", i), 64'(cnt[1]), 64'(0));
            check($sformatf("flush_vld_%0d", i), 64'(ov[1]), 64'(0));
            cycle();
        end

        // Asynchronous reset with three buffered and two in flight.
        ordy[1] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            iv[1] = 1'b1; op[1] = XW'(300 + i);
            cycle();
        end
        iv[1] = 1'b0;
        cycle();
        check("prerst_cnt", 64'(cnt[1]), 64'(3));
        check("prerst_inflight", 64'(inflight(1)), 64'(2));
        arst_n = 1'b0;
        #1;
        check_reset_outputs("midrst", 1);
        for (int k = 0; k < 2; k++) mclear(k);
        @(negedge aclk);
        arst_n = 1'b1;
        ordy[1] = 1'b1;
        repeat (6) cycle();
        check("postrst_vld", 64'(ov[1]), 64'(0));

        // Randomised traffic with occasional flushes, alternating consumer pressure.
        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 99) < 60);
                op[k]   = XW'({$urandom, $urandom});
                fl[k]   = ($urandom_range(0, 299) == 0);
                ordy[k] = ($urandom_range(0, 99) < (((n / 500) % 2 == 0) ? 30 : 80));
            end
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1;
        end
        repeat (20) cycle();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("conserve%0d", k), 64'(delivered[k]), 64'(accepted[k] - discarded[k]));
            check($sformatf("final_cnt%0d", k), 64'(cnt[k]), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/float_div_rcp_result_collect.md
FLOAT_DIV_RCP_RESULT_COLLECT -- requirements
Module: float_div_rcp_result_collect

Interface
REQ-001 SHALL have parameter LATENCY, default 1: number of enabled register stages between operand issue and a valid x on the reciprocal pipe output (legal 1..8).
REQ-002 SHALL have parameter DEPTH, default 4: result FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter XW, default 37: width of the reciprocal pipe result word.
REQ-004 aclk  input  1  sole clock; all state on rising edge.
REQ-005 arst_n  input  1  asynchronous, active-low reset.
REQ-006 issue_vld  input  1  an operand is presented to the reciprocal pipe input this cycle.
REQ-007 issue_rdy  output  1  operand is accepted into the pipe this cycle; equals ~astall.
REQ-008 astall  output  1  stall to the reciprocal pipe; high freezes every pipe stage.
REQ-009 rcp_x  input  XW  result word from the reciprocal pipe output register.
REQ-010 flush  input  1  synchronous discard of all in-flight and buffered results.
REQ-011 out_vld  output  1  out_x holds the oldest buffered result.
REQ-012 out_rdy  input  1  downstream accepts out_x when out_vld is high.
REQ-013 out_x  output  XW  oldest buffered result.
REQ-014 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-015 An operand SHALL be issued when issue_vld & issue_rdy are both high.
REQ-016 Shadow valid shift register vld[LATENCY-1:0] SHALL track the pipe: when astall is low, vld[0] <= issued and vld[i] <= vld[i-1]; when astall is high, vld SHALL hold.
REQ-017 rcp_x SHALL be valid exactly when vld[LATENCY-1] is high; with no stall, a result issued at cycle t is presented at cycle t+LATENCY.
REQ-018 Push SHALL occur when vld[LATENCY-1] & ~astall; rcp_x is written at the FIFO tail.
REQ-019 astall SHALL be vld[LATENCY-1] & (count == DEPTH), driven only from registered state (no combinational path from out_rdy, issue_vld or rcp_x).
REQ-020 Pop SHALL occur when out_vld & out_rdy; the head pointer advances.
REQ-021 out_vld SHALL be (count != 0); out_x SHALL be the head entry, stable while out_vld & ~out_rdy.
REQ-022 A push and a pop in the same cycle SHALL leave count unchanged; with count == 0 a push SHALL NOT bypass to out_x in that cycle (first result visible the following cycle).
REQ-023 Push SHALL never occur at count == DEPTH (guaranteed by REQ-019); pop at count == 0 SHALL be impossible (out_vld low).
REQ-024 When full and popped, astall SHALL deassert in the next cycle and the held result SHALL be pushed then; no result is lost or duplicated.
REQ-025 Pointers SHALL wrap modulo DEPTH; count SHALL saturate neither way (bounded by REQ-023).
REQ-026 Results SHALL leave in issue order.
REQ-027 flush SHALL, at the next edge, clear vld, count and pointers; it takes priority over issue, push and pop that cycle; an issue in the flush cycle is discarded.

Reset
REQ-028 While arst_n is low: vld = 0, count = 0, pointers = 0, out_vld = 0, out_x = 0, astall = 0, issue_rdy = 1.
REQ-029 Reset asserted mid-operation SHALL immediately discard all in-flight and buffered results; FIFO storage contents need not be cleared, but out_x SHALL read 0 while empty after reset.
REQ-030 Deassertion SHALL be synchronised externally; the block SHALL operate from the first edge after arst_n rises.

Verification
REQ-031 LATENCY=1, out_rdy=1, issue A at cycle 0 with rcp_x=37'h0_0000_1234 at cycle 1 -> out_vld=1, out_x=37'h0_0000_1234 at cycle 2, count back to 0 at cycle 3.
REQ-032 DEPTH=4, out_rdy=0, issue 5 back-to-back -> count reaches 4, astall=1 while fifth result sits on rcp_x, issue_rdy=0; raise out_rdy one cycle -> astall=0 the next cycle, fifth result pushed, count=4, order 1..5 preserved on drain.
REQ-033 Simultaneous push and pop at count=2 -> count stays 2, out_x advances to next entry.
REQ-034 LATENCY=3, issue on cycles 0,1,2 with flush on cycle 2 -> no pushes ever, count=0, out_vld=0.
REQ-035 arst_n low at cycle 5 with count=3 and two in flight -> out_vld=0, count=0, astall=0 immediately; no stale result emerges after release.
REQ-036 Random issue/out_rdy for 10k cycles with scoreboard -> every issued result delivered exactly once, in order, count never exceeds DEPTH.
